// File: rtl/palette_fade_ctrl_pkg.sv
// Shared definitions for the palette fade controller: geometry, channel
// positions, fade sequencer state encodings and level saturation.
package palette_fade_ctrl_pkg;

   localparam int PAL_ENTRIES = 256;
   localparam int PAL_AW      = $clog2(PAL_ENTRIES);

   localparam logic [4:0] PAL_LEVEL_MAX = 5'd16;

   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   function automatic logic [4:0] sat_level(input logic [4:0] level);
      return (level > PAL_LEVEL_MAX) ? PAL_LEVEL_MAX : level;
   endfunction

endpackage

// File: rtl/palette_scale.sv
// Scales a 12-bit RGB444 colour by a 0..16 brightness level; 16 is identity.
// Purely combinational so the composer can reuse it for global brightness.
module palette_scale
   import palette_fade_ctrl_pkg::*;
(
   input  logic [11:0] color,
   input  logic [4:0]  level,
   output logic [15:0] word
);

   function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] l);
      logic [8:0] prod;
      prod = {5'd0, c} * {4'd0, l};
      return 4'(prod >> 4);
   endfunction

   assign word = {4'd0,
                  scale_chan(color[R_MSB:R_LSB], level),
                  scale_chan(color[G_MSB:G_LSB], level),
                  scale_chan(color[B_MSB:B_LSB], level)};

endmodule

// File: rtl/palette_fade_ctrl.sv
// Palette RAM port arbiter: composer reads, CPU writes, and a fade sequencer
// that copies and brightness-scales a range of entries during vertical blank.
module palette_fade_ctrl
   import palette_fade_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [PAL_AW-1:0] src_i,
   input  logic [PAL_AW-1:0] dst_i,
   input  logic [PAL_AW:0]   count_i,
   input  logic [4:0]        level_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              vblank_i,
   input  logic [PAL_AW-1:0] vid_rd_addr_i,
   input  logic              cpu_wr_en_i,
   input  logic [1:0]        cpu_ben_i,
   input  logic [PAL_AW-1:0] cpu_wr_addr_i,
   input  logic [15:0]       cpu_wr_data_i,
   output logic [PAL_AW-1:0] pal_rd_addr_o,
   input  logic [15:0]       pal_rd_data_i,
   output logic              pal_wr_en_o,
   output logic [1:0]        pal_ben_o,
   output logic [PAL_AW-1:0] pal_wr_addr_o,
   output logic [15:0]       pal_wr_data_o
);

   localparam logic [PAL_AW-1:0] ADDR_ONE = 1;
   localparam logic [PAL_AW:0]   REM_ONE  = 1;

   logic [2:0]        state;
   logic [PAL_AW-1:0] src_q;
   logic [PAL_AW-1:0] dst_q;
   logic [PAL_AW:0]   rem_q;
   logic [4:0]        level_q;
   logic [11:0]       color_q;
   logic [15:0]       fade_word;
   logic              fade_rd;
   logic              unused_rd_hi;

   // The fade rewrites bits [15:12] as zero, so the captured top nibble is dropped.
   assign unused_rd_hi = ^pal_rd_data_i[15:12];

   // A zero-length fade still passes through RD once, which places done_o
   // two cycles after start without touching either RAM port.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         level_q <= '0;
         color_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  src_q   <= src_i;
                  dst_q   <= dst_i;
                  rem_q   <= count_i;
                  level_q <= sat_level(level_i);
                  state   <= ST_RD;
               end
            end
            ST_RD: begin
               if (rem_q == '0) begin
                  state <= ST_DONE;
               end else if (vblank_i) begin
                  state <= ST_CAP;
               end
            end
            ST_CAP: begin
               color_q <= pal_rd_data_i[11:0];
               state   <= ST_WR;
            end
            ST_WR: begin
               if (!cpu_wr_en_i) begin
                  src_q <= src_q + ADDR_ONE;
                  dst_q <= dst_q + ADDR_ONE;
                  rem_q <= rem_q - REM_ONE;
                  state <= (rem_q == REM_ONE) ? ST_DONE : ST_RD;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   palette_scale u_scale (
      .color (color_q),
      .level (level_q),
      .word  (fade_word)
   );

   assign busy_o  = (state != ST_IDLE);
   assign done_o  = (state == ST_DONE);
   assign fade_rd = (state == ST_RD) && vblank_i && (rem_q != '0);

   // NOTE: each always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pal_rd_addr_o = vid_rd_addr_i;
      if (fade_rd) begin
         pal_rd_addr_o = src_q;
      end
   end

   // CPU writes always win; a pending fade write simply waits in WR.
   always_comb begin
      pal_wr_en_o   = 1'b0;
      pal_ben_o     = 2'b00;
      pal_wr_addr_o = '0;
      pal_wr_data_o = '0;
      if (cpu_wr_en_i) begin
         pal_wr_en_o   = 1'b1;
         pal_ben_o     = cpu_ben_i;
         pal_wr_addr_o = cpu_wr_addr_i;
         pal_wr_data_o = cpu_wr_data_i;
      end else if (state == ST_WR) begin
         pal_wr_en_o   = 1'b1;
         pal_ben_o     = 2'b11;
         pal_wr_addr_o = dst_q;
         pal_wr_data_o = fade_word;
      end
   end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench for palette_fade_ctrl: behavioural palette RAM, a
// transaction-level expectation queue, directed cases and randomized fades.
module tb_palette_fade_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        start_i;
   logic [7:0]  src_i;
   logic [7:0]  dst_i;
   logic [8:0]  count_i;
   logic [4:0]  level_i;
   logic        busy_o;
   logic        done_o;
   logic        vblank_i;
   logic [7:0]  vid_rd_addr_i;
   logic        cpu_wr_en_i;
   logic [1:0]  cpu_ben_i;
   logic [7:0]  cpu_wr_addr_i;
   logic [15:0] cpu_wr_data_i;
   logic [7:0]  pal_rd_addr_o;
   logic [15:0] pal_rd_data_i;
   logic        pal_wr_en_o;
   logic [1:0]  pal_ben_o;
   logic [7:0]  pal_wr_addr_o;
   logic [15:0] pal_wr_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   palette_fade_ctrl dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .start_i       (start_i),
      .src_i         (src_i),
      .dst_i         (dst_i),
      .count_i       (count_i),
      .level_i       (level_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .vblank_i      (vblank_i),
      .vid_rd_addr_i (vid_rd_addr_i),
      .cpu_wr_en_i   (cpu_wr_en_i),
      .cpu_ben_i     (cpu_ben_i),
      .cpu_wr_addr_i (cpu_wr_addr_i),
      .cpu_wr_data_i (cpu_wr_data_i),
      .pal_rd_addr_o (pal_rd_addr_o),
      .pal_rd_data_i (pal_rd_data_i),
      .pal_wr_en_o   (pal_wr_en_o),
      .pal_ben_o     (pal_ben_o),
      .pal_wr_addr_o (pal_wr_addr_o),
      .pal_wr_data_o (pal_wr_data_o)
   );

   // Behavioural palette RAM: byte-enabled write, one-cycle registered read.
   logic [15:0] ram [256];
   logic [15:0] rd_q;
   always @(posedge clk_i) begin
      if (pal_wr_en_o) begin
         if (pal_ben_o[0]) ram[pal_wr_addr_o][7:0]  <= pal_wr_data_o[7:0];
         if (pal_ben_o[1]) ram[pal_wr_addr_o][15:8] <= pal_wr_data_o[15:8];
      end
      rd_q <= ram[pal_rd_addr_o];
   end
   assign pal_rd_data_i = rd_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Brightness model written straight from the channel rule: floor(c*L/16).
   function automatic logic [15:0] model_scale(input logic [15:0] w, input int lvl);
      int l, r, g, b;
      l = (lvl > 16) ? 16 : lvl;
      r = (int'(w) / 256) % 16;
      g = (int'(w) / 16) % 16;
      b = int'(w) % 16;
      return 16'((r * l / 16) * 256 + (g * l / 16) * 16 + (b * l / 16));
   endfunction

   // Expected fade traffic, in issue order.
   logic [7:0]  exp_ra [$];
   logic [7:0]  exp_wa [$];
   logic [15:0] exp_wd [$];

   task automatic setup_expect(input logic [7:0] src, input logic [7:0] dst,
                               input int cnt, input int lvl);
      exp_ra.delete();
      exp_wa.delete();
      exp_wd.delete();
      for (int i = 0; i < cnt; i++) begin
         exp_ra.push_back(8'((int'(src) + i) % 256));
         exp_wa.push_back(8'((int'(dst) + i) % 256));
         exp_wd.push_back(model_scale(ram[8'((int'(src) + i) % 256)], lvl));
      end
   endtask

   // Per-cycle port checker against the expectation queues.
   always @(negedge clk_i) begin
      if (rst_n_i === 1'b1) begin
         if (!(busy_o && vblank_i)) begin
            check("rd_mux_vid", pal_rd_addr_o, vid_rd_addr_i);
         end else if (pal_rd_addr_o != vid_rd_addr_i) begin
            check("fade_rd_queued", exp_ra.size() > 0, 1);
            if (exp_ra.size() > 0) check("fade_rd_addr", pal_rd_addr_o, exp_ra.pop_front());
         end
         if (cpu_wr_en_i) begin
            check("cpu_passthrough", {pal_wr_en_o, pal_ben_o, pal_wr_addr_o, pal_wr_data_o},
                  {1'b1, cpu_ben_i, cpu_wr_addr_i, cpu_wr_data_i});
         end else if (pal_wr_en_o) begin
            check("fade_wr_queued", exp_wa.size() > 0, 1);
            if (exp_wa.size() > 0) begin
               check("fade_wr_ben", pal_ben_o, 2'b11);
               check("fade_wr_addr", pal_wr_addr_o, exp_wa.pop_front());
               check("fade_wr_data", pal_wr_data_o, exp_wd.pop_front());
            end
         end
         if (done_o) begin
            check("done_reads_left", exp_ra.size(), 0);
            check("done_writes_left", exp_wa.size(), 0);
         end
      end
   end

   task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
      cpu_wr_en_i   = 1'b1;
      cpu_ben_i     = 2'b11;
      cpu_wr_addr_i = a;
      cpu_wr_data_i = d;
      @(posedge clk_i); #1;
      cpu_wr_en_i = 1'b0;
   endtask

   // Runs one fade from a start pulse at cycle 0 and reports the done cycle.
   task automatic run_fade(input logic [7:0] src, input logic [7:0] dst, input int cnt,
                           input int lvl, input int stall_at, input int vb_lo_at,
                           input int vb_lo_len, input bit rnd,
                           output int done_cyc, output int busy_cyc);
      logic [15:0] fin [$];
      setup_expect(src, dst, cnt, lvl);
      fin = exp_wd;
      done_cyc = -1;
      busy_cyc = 0;
      for (int k = 0; k < 3000; k++) begin
         if (k == 0) begin
            start_i = 1'b1;
            src_i   = src;
            dst_i   = dst;
            count_i = 9'(cnt);
            level_i = 5'(lvl);
         end else begin
            start_i = (k == 5) && (cnt >= 2);
            src_i   = 8'($urandom);
            dst_i   = 8'($urandom);
            count_i = 9'($urandom);
            level_i = 5'($urandom);
         end
         cpu_wr_en_i = 1'b0;
         if ((stall_at >= 0 && k >= stall_at && k < stall_at + 3) ||
             (rnd && $urandom_range(3) == 0)) begin
            cpu_wr_en_i   = 1'b1;
            cpu_ben_i     = 2'($urandom);
            cpu_wr_addr_i = 8'(8'hA0 + $urandom_range(31));
            cpu_wr_data_i = 16'($urandom);
         end
         vblank_i = rnd ? ($urandom_range(3) != 0) : !(k >= vb_lo_at && k < vb_lo_at + vb_lo_len);
         vid_rd_addr_i = 8'(8'hC0 + $urandom_range(31));
         @(negedge clk_i);
         if (busy_o) busy_cyc++;
         if (done_o && done_cyc < 0) done_cyc = k;
         @(posedge clk_i); #1;
         if (done_cyc >= 0) break;
      end
      start_i     = 1'b0;
      cpu_wr_en_i = 1'b0;
      vblank_i    = 1'b1;
      check("done_seen", done_cyc >= 0, 1);
      for (int i = 0; i < cnt; i++) begin
         check("dst_contents", ram[8'((int'(dst) + i) % 256)], fin[i]);
      end
   endtask

   int dc, bc, nw;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i = 1'b0; start_i = 1'b0; src_i = '0; dst_i = '0; count_i = '0; level_i = '0;
      vblank_i = 1'b1; vid_rd_addr_i = 8'hC5; cpu_wr_en_i = 1'b0; cpu_ben_i = '0;
      cpu_wr_addr_i = '0; cpu_wr_data_i = '0;
      @(posedge clk_i); @(posedge clk_i); #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_wr_en", pal_wr_en_o, 0);
      check("rst_rd_addr", pal_rd_addr_o, 8'hC5);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      for (int a = 0; a < 256; a++) cpu_write(8'(a), 16'($urandom));
      cpu_write(8'h80, 16'h0FFF);
      cpu_write(8'h81, 16'h0123);
      cpu_write(8'h82, 16'h0A50);
      cpu_write(8'h83, 16'h0000);
      cpu_write(8'h84, 16'h0F84);
      cpu_write(8'h85, 16'hAF84);
      cpu_write(8'h86, 16'h0777);
      cpu_write(8'h87, 16'h0321);
      for (int a = 0; a < 4; a++) cpu_write(8'(a), 16'hFFFF);

      // Identity copy: done at 3N+1, busy for cycles 1..13.
      run_fade(8'h80, 8'h00, 4, 16, -1, -1, 0, 1'b0, dc, bc);
      check("t1_done_cycle", dc, 13);
      check("t1_busy_cycles", bc, 13);
      check("t1_busy_after", busy_o, 0);
      check("t1_dst0", ram[8'h00], 16'h0FFF);
      check("t1_dst1", ram[8'h01], 16'h0123);
      check("t1_dst2", ram[8'h02], 16'h0A50);
      check("t1_dst3", ram[8'h03], 16'h0000);

      // Half brightness, top nibble cleared; black; oversaturated level.
      run_fade(8'h84, 8'h10, 2, 8, -1, -1, 0, 1'b0, dc, bc);
      check("l8_done_cycle", dc, 7);
      check("l8_dst0", ram[8'h10], 16'h0742);
      check("l8_dst1", ram[8'h11], 16'h0742);
      run_fade(8'h84, 8'h12, 2, 0, -1, -1, 0, 1'b0, dc, bc);
      check("l0_dst0", ram[8'h12], 16'h0000);
      run_fade(8'h80, 8'h20, 4, 31, -1, -1, 0, 1'b0, dc, bc);
      check("l31_dst0", ram[8'h20], 16'h0FFF);
      check("l31_dst1", ram[8'h21], 16'h0123);

      // vblank low for cycles 2..11: capture at 2 completes, next RD waits until 12.
      run_fade(8'h80, 8'h30, 4, 16, -1, 2, 10, 1'b0, dc, bc);
      check("vb_done_cycle", dc, 21);

      // CPU holds the write port for three cycles of the first WR.
      run_fade(8'h80, 8'h40, 2, 16, 3, -1, 0, 1'b0, dc, bc);
      check("stall_done_cycle", dc, 10);

      // Destination wraps past 0xFF.
      for (int a = 0; a < 4; a++) cpu_write(8'((254 + a) % 256), 16'h5555);
      run_fade(8'h80, 8'hFE, 4, 16, -1, -1, 0, 1'b0, dc, bc);
      check("wrap_done_cycle", dc, 13);
      check("wrap_fe", ram[8'hFE], 16'h0FFF);
      check("wrap_ff", ram[8'hFF], 16'h0123);
      check("wrap_00", ram[8'h00], 16'h0A50);
      check("wrap_01", ram[8'h01], 16'h0000);

      // Zero-length fade.
      run_fade(8'h80, 8'h60, 0, 16, -1, -1, 0, 1'b0, dc, bc);
      check("zero_done_cycle", dc, 2);
      check("zero_busy_cycles", bc, 2);

      // Reset after the second of eight writes.
      for (int a = 0; a < 8; a++) cpu_write(8'(8'h50 + a), 16'h1234);
      setup_expect(8'h80, 8'h50, 8, 16);
      src_i = 8'h80; dst_i = 8'h50; count_i = 9'd8; level_i = 5'd16; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      nw = 0;
      for (int k = 0; k < 200 && nw < 2; k++) begin
         @(negedge clk_i);
         if (pal_wr_en_o && !cpu_wr_en_i) nw++;
         @(posedge clk_i); #1;
      end
      check("rst_mid_writes", nw, 2);
      rst_n_i = 1'b0; #1;
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_wr_en", pal_wr_en_o, 0);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      for (int k = 0; k < 30; k++) begin @(posedge clk_i); #1; end
      check("rst_mid_idle", busy_o, 0);
      check("rst_mid_dst0", ram[8'h50], 16'h0FFF);
      check("rst_mid_dst1", ram[8'h51], 16'h0123);
      for (int a = 2; a < 8; a++) check("rst_mid_untouched", ram[8'(8'h50 + a)], 16'h1234);

      // Randomized fades with random vblank and CPU traffic.
      for (int t = 0; t < 20; t++) begin
         run_fade(8'(8'h40 + $urandom_range(31)), 8'(8'hE0 + $urandom_range(63)),
                  1 + int'($urandom_range(31)), int'($urandom_range(31)),
                  -1, -1, 0, 1'b1, dc, bc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
